uart_cmd_sequencer: RTL
=======================

UART_CMD_SEQUENCER -- requirements
Module: uart_cmd_sequencer

Interface
REQ-001 SHALL have parameter SWRST_CYCLES, default 8: sw_rst pulse width in clk cycles (range 1-255).
REQ-002 SHALL have parameter NUM_CFG, default 4: number of 8-bit configuration registers (range 1-16).
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 fifo_empty  in  1  rx byte FIFO empty flag.
REQ-006 fifo_re  out  1  rx FIFO read strobe; data returns next cycle.
REQ-007 fifo_out_valid / fifo_out_data  in  1 / 8  rx FIFO read response.
REQ-008 rx_block_timeout  in  1  one-cycle pulse: UART line idle after a block.
REQ-009 send_trig / send_data  out  1 / 8  uart_tx request and byte.
REQ-010 tx_bsy  in  1  uart_tx busy.
REQ-011 done  in  1  accelerator completion level.
REQ-012 sw_rst / start  out  1 / 1  accelerator soft reset and start pulse.
REQ-013 cfg  out  8*NUM_CFG  flattened config registers; cfg[8i+7:8i] is register i.

Function
REQ-014 Opcodes: 0x01 RESET, 0x02 START, 0x03 WR_CFG(addr,data), 0x04 RD_CFG(addr), 0x05 STATUS; others illegal.
REQ-015 States: IDLE, FETCH, WAIT_BYTE, DECODE, EXEC, PULSE_RST, SEND, SEND_WAIT.
REQ-016 IDLE -> FETCH when fifo_empty=0; FETCH drives fifo_re=1 for exactly one cycle; WAIT_BYTE captures fifo_out_data when fifo_out_valid=1.
REQ-017 At most one FIFO read outstanding; fifo_re never asserted in two consecutive cycles.
REQ-018 DECODE: after opcode byte, fetch 2 arg bytes for WR_CFG, 1 for RD_CFG, 0 otherwise, via FETCH/WAIT_BYTE; then EXEC.
REQ-019 RESET: sw_rst=1 for exactly SWRST_CYCLES cycles (PULSE_RST counter), then reply 0xA1.
REQ-020 START: start=1 for exactly one cycle in EXEC; reply 0xA2.
REQ-021 WR_CFG: addr<NUM_CFG writes data to register addr in EXEC, reply 0xA3; addr>=NUM_CFG writes nothing, reply 0xEE.
REQ-022 RD_CFG: addr<NUM_CFG replies register value; otherwise 0xEE.
REQ-023 STATUS: reply {6'b0, done, busy_flag}; busy_flag sets on START, clears on first cycle done=1.
REQ-024 Illegal opcode: reply 0xEE, consume no further bytes.
REQ-025 SEND: send_data loaded, send_trig=1 single cycle only while tx_bsy=0; SEND_WAIT holds send_data stable until tx_bsy falls, then IDLE.
REQ-026 rx_block_timeout while awaiting an argument byte with fifo_empty=1: abort command, no side effects, reply 0xEE.
REQ-027 rx_block_timeout in any other state: ignored.
REQ-028 Commands strictly sequential; next opcode fetched only after reply transmission completes.
REQ-029 Opcode-to-reply latency for START with tx_bsy=0: send_trig within 4 cycles of fifo_out_valid of opcode.

Reset
REQ-030 rst=0 asynchronously forces IDLE; fifo_re, send_trig, sw_rst, start = 0; send_data = 0x00; cfg all 0x00; busy_flag = 0; counters 0.
REQ-031 Reset mid-command or mid-PULSE_RST discards command and terminates pulse immediately; no reply sent.
REQ-032 Outputs leave reset values on first posedge after rst deasserts.

Structure
REQ-033 Opcode values, reply codes (0xA1-0xA3, 0xEE), and state encodings in a shared package/include file.
REQ-034 Single sub-module natural: cmd_arg_collector (byte fetch handshake, arg count, timeout abort).
REQ-035 uart_rx, uart_tx, fifo instantiated by parent, not inside this block.

Verification
REQ-036 FIFO bytes 0x02 -> start high one cycle, tx byte 0xA2, cfg unchanged.
REQ-037 Bytes 0x03,0x02,0x5A then 0x04,0x02 -> cfg[23:16]=0x5A, replies 0xA3 then 0x5A.
REQ-038 Byte 0x01, SWRST_CYCLES=8 -> sw_rst high exactly 8 cycles, reply 0xA1.
REQ-039 Byte 0x03,0x01 then rx_block_timeout pulse with FIFO empty -> cfg unchanged, reply 0xEE, next 0x05 answers 0x00.
REQ-040 Bytes 0x7F and 0x03,0x09,0x11 (NUM_CFG=4) -> replies 0xEE, 0xEE, no cfg change.
REQ-041 rst low during PULSE_RST cycle 3 -> sw_rst 0 immediately, no tx trigger, IDLE after release.

Source files
------------

// File: rtl/uart_cmd_sequencer_pkg.sv
// Shared definitions for the UART command sequencer: opcodes, reply codes,
// FSM state encoding and the opcode -> argument-count helper.
package uart_cmd_sequencer_pkg;

  localparam logic [7:0] OP_RESET  = 8'h01;
  localparam logic [7:0] OP_START  = 8'h02;
  localparam logic [7:0] OP_WR_CFG = 8'h03;
  localparam logic [7:0] OP_RD_CFG = 8'h04;
  localparam logic [7:0] OP_STATUS = 8'h05;

  localparam logic [7:0] RPL_RESET = 8'hA1;
  localparam logic [7:0] RPL_START = 8'hA2;
  localparam logic [7:0] RPL_WR_OK = 8'hA3;
  localparam logic [7:0] RPL_ERR   = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_BYTE,
    S_DECODE,
    S_EXEC,
    S_PULSE_RST,
    S_SEND,
    S_SEND_WAIT
  } state_e;

  // Number of argument bytes following an opcode; illegal opcodes take none.
  function automatic logic [1:0] arg_count(input logic [7:0] op);
    case (op)
      OP_WR_CFG: arg_count = 2'd2;
      OP_RD_CFG: arg_count = 2'd1;
      default:   arg_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// Bus bundle between the command sequencer and its surroundings
// (rx FIFO, uart_tx, accelerator, config register outputs).
//   master : the sequencer (drives fifo_re, send_*, sw_rst, start, cfg)
//   slave  : the environment (drives FIFO status/data, tx_bsy, done, timeout)
interface uart_cmd_sequencer_if #(
  parameter int unsigned NUM_CFG = 4
);
  logic                   fifo_empty;
  logic                   fifo_re;
  logic                   fifo_out_valid;
  logic [7:0]             fifo_out_data;
  logic                   rx_block_timeout;
  logic                   send_trig;
  logic [7:0]             send_data;
  logic                   tx_bsy;
  logic                   done;
  logic                   sw_rst;
  logic                   start;
  logic [8*NUM_CFG-1:0]   cfg;

  modport master (
    input  fifo_empty, fifo_out_valid, fifo_out_data, rx_block_timeout, tx_bsy, done,
    output fifo_re, send_trig, send_data, sw_rst, start, cfg
  );

  modport slave (
    output fifo_empty, fifo_out_valid, fifo_out_data, rx_block_timeout, tx_bsy, done,
    input  fifo_re, send_trig, send_data, sw_rst, start, cfg
  );
endinterface

// File: rtl/uart_cmd_sequencer_cmd_arg_collector.sv
// Collects the opcode and argument bytes of one command.
//   i_clear            : drop any partial command (sequencer idle)
//   i_byte_vld/i_byte  : a byte returned by the rx FIFO
//   i_awaiting         : sequencer is waiting for an argument byte
//   i_fifo_empty       : rx FIFO empty flag
//   i_rx_block_timeout : line-idle pulse
//   o_opcode/o_arg0/o_arg1 : collected command (arg0 = first argument)
//   o_need_arg         : more argument bytes still required
//   o_abort            : timeout while starved of an argument byte
module cmd_arg_collector
  import uart_cmd_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_byte_vld,
  input  logic [7:0] i_byte,
  input  logic       i_awaiting,
  input  logic       i_fifo_empty,
  input  logic       i_rx_block_timeout,
  output logic [7:0] o_opcode,
  output logic [7:0] o_arg0,
  output logic [7:0] o_arg1,
  output logic       o_need_arg,
  output logic       o_abort
);
  logic       r_have_op;
  logic       r_got_arg0;
  logic [1:0] r_args_left;
  logic [7:0] r_opcode;
  logic [7:0] r_arg0;
  logic [7:0] r_arg1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_have_op   <= 1'b0;
      r_got_arg0  <= 1'b0;
      r_args_left <= '0;
      r_opcode    <= '0;
      r_arg0      <= '0;
      r_arg1      <= '0;
    end else if (i_clear) begin
      r_have_op   <= 1'b0;
      r_got_arg0  <= 1'b0;
      r_args_left <= '0;
    end else if (i_byte_vld) begin
      if (!r_have_op) begin
        r_have_op   <= 1'b1;
        r_opcode    <= i_byte;
        r_args_left <= arg_count(i_byte);
      end else begin
        if (!r_got_arg0) begin
          r_arg0     <= i_byte;
          r_got_arg0 <= 1'b1;
        end else begin
          r_arg1 <= i_byte;
        end
        r_args_left <= r_args_left - 2'd1;
      end
    end
  end

  assign o_opcode   = r_opcode;
  assign o_arg0     = r_arg0;
  assign o_arg1     = r_arg1;
  assign o_need_arg = r_have_op && (r_args_left != 2'd0);
  assign o_abort    = i_awaiting && o_need_arg && i_fifo_empty && i_rx_block_timeout;

endmodule

// File: rtl/uart_cmd_sequencer.sv
// UART command sequencer: reads command bytes from the rx FIFO, executes
// RESET/START/WR_CFG/RD_CFG/STATUS and replies with one byte via uart_tx.
//   clk  : clock, all logic on posedge
//   rst  : asynchronous active-low reset
//   bus  : master side of uart_cmd_sequencer_if (FIFO, tx, accelerator, cfg)
module uart_cmd_sequencer
  import uart_cmd_sequencer_pkg::*;
#(
  parameter int unsigned SWRST_CYCLES = 8,
  parameter int unsigned NUM_CFG      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_cmd_sequencer_if.master  bus
);
  localparam logic [7:0] CFG_LIMIT  = 8'(NUM_CFG);
  localparam logic [7:0] SWRST_LAST = 8'(SWRST_CYCLES - 1);

  state_e               r_state;
  logic                 r_fifo_re;
  logic                 r_send_trig;
  logic [7:0]           r_send_data;
  logic                 r_sw_rst;
  logic                 r_start;
  logic                 r_busy;
  logic [7:0]           r_cnt;
  logic [8*NUM_CFG-1:0] r_cfg;

  logic [7:0] w_opcode;
  logic [7:0] w_arg0;
  logic [7:0] w_arg1;
  logic       w_need_arg;
  logic       w_abort;
  logic       w_addr_ok;
  logic [7:0] w_rd_data;

  cmd_arg_collector u_collector (
    .clk                (clk),
    .rst                (rst),
    .i_clear            (r_state == S_IDLE),
    .i_byte_vld         ((r_state == S_WAIT_BYTE) && bus.fifo_out_valid),
    .i_byte             (bus.fifo_out_data),
    .i_awaiting         (r_state == S_DECODE),
    .i_fifo_empty       (bus.fifo_empty),
    .i_rx_block_timeout (bus.rx_block_timeout),
    .o_opcode           (w_opcode),
    .o_arg0             (w_arg0),
    .o_arg1             (w_arg1),
    .o_need_arg         (w_need_arg),
    .o_abort            (w_abort)
  );

  assign w_addr_ok = (w_arg0 < CFG_LIMIT);

  always_comb begin
    w_rd_data = '0;
    for (int unsigned i = 0; i < NUM_CFG; i++) begin
      if (w_arg0 == 8'(i)) w_rd_data = r_cfg[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_fifo_re   <= 1'b0;
      r_send_trig <= 1'b0;
      r_send_data <= '0;
      r_sw_rst    <= 1'b0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
      r_cfg       <= '0;
    end else begin
      r_fifo_re   <= 1'b0;
      r_send_trig <= 1'b0;
      r_start     <= 1'b0;

      // Busy is set by the start pulse itself so a stale done from the
      // previous run cannot clear it in the same cycle.
      if (r_start)       r_busy <= 1'b1;
      else if (bus.done) r_busy <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!bus.fifo_empty) begin
            r_fifo_re <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_WAIT_BYTE;
        S_WAIT_BYTE: begin
          if (bus.fifo_out_valid) r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (w_abort) begin
            r_send_data <= RPL_ERR;
            r_state     <= S_SEND;
          end else if (w_need_arg) begin
            if (!bus.fifo_empty) begin
              r_fifo_re <= 1'b1;
              r_state   <= S_FETCH;
            end
          end else begin
            r_start <= (w_opcode == OP_START);
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_state <= S_SEND;
          case (w_opcode)
            OP_RESET: begin
              r_sw_rst <= 1'b1;
              r_cnt    <= '0;
              r_state  <= S_PULSE_RST;
            end
            OP_START: r_send_data <= RPL_START;
            OP_WR_CFG: begin
              for (int unsigned i = 0; i < NUM_CFG; i++) begin
                if (w_arg0 == 8'(i)) r_cfg[8*i +: 8] <= w_arg1;
              end
              r_send_data <= w_addr_ok ? RPL_WR_OK : RPL_ERR;
            end
            OP_RD_CFG: r_send_data <= w_addr_ok ? w_rd_data : RPL_ERR;
            OP_STATUS: r_send_data <= {6'b0, bus.done, r_busy};
            default:   r_send_data <= RPL_ERR;
          endcase
        end
        S_PULSE_RST: begin
          if (r_cnt == SWRST_LAST) begin
            r_sw_rst    <= 1'b0;
            r_cnt       <= '0;
            r_send_data <= RPL_RESET;
            r_state     <= S_SEND;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_SEND: begin
          if (!bus.tx_bsy) begin
            r_send_trig <= 1'b1;
            r_state     <= S_SEND_WAIT;
          end
        end
        S_SEND_WAIT: begin
          // uart_tx raises busy the cycle after the trigger, so the trigger
          // cycle itself is never taken as "transmission finished".
          if (!r_send_trig && !bus.tx_bsy) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.fifo_re   = r_fifo_re;
  assign bus.send_trig = r_send_trig;
  assign bus.send_data = r_send_data;
  assign bus.sw_rst    = r_sw_rst;
  assign bus.start     = r_start;
  assign bus.cfg       = r_cfg;

endmodule
